// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Byte-serial memory bus target with on-chip RAM and an I/O window
//            holding TX/RX byte FIFOs for an external serial port.
// Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ram_rw,
  input  logic [31:0] ram_addr,
  input  logic [7:0]  ram_w_data,
  output logic [7:0]  ram_r_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_overflow
);

  localparam int                 c_FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   c_CNT_FULL   = (FIFO_AW + 1)'(c_FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   c_CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] c_PTR_ONE    = FIFO_AW'(1);

  logic [7:0]         r_ram    [2**RAM_AW];
  logic [7:0]         r_tx_mem [c_FIFO_DEPTH];
  logic [7:0]         r_rx_mem [c_FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [FIFO_AW:0]   r_tx_cnt, r_rx_cnt;
  logic               r_tx_overflow;
  logic [7:0]         r_rd_data;

  logic       w_io, w_io_data, w_io_stat;
  logic       w_tx_full, w_tx_push_req, w_tx_push, w_tx_pop;
  logic       w_rx_nonempty, w_rx_pop, w_rx_push;
  logic [7:0] w_rd_next;
  logic       w_unused_addr;

  // Only bits [17:16] select the I/O window; upper address bits are ignored.
  assign w_io      = (ram_addr[17:16] == 2'b11);
  assign w_io_data = w_io && (ram_addr[2:0] == 3'd0);
  assign w_io_stat = w_io && (ram_addr[2:0] == 3'd4);
  assign w_unused_addr = ^ram_addr;

  // TX fullness is judged on the pre-edge count, so a pop cannot make room.
  assign w_tx_full     = (r_tx_cnt == c_CNT_FULL);
  assign w_tx_push_req = ram_rw && w_io_data;
  assign w_tx_push     = w_tx_push_req && !w_tx_full;
  assign w_tx_pop      = tx_valid && tx_ready;

  assign w_rx_nonempty = (r_rx_cnt != '0);
  assign w_rx_pop      = !ram_rw && w_io_data && w_rx_nonempty;
  assign w_rx_push     = rx_valid && rx_ready;

  assign tx_valid    = (r_tx_cnt != '0);
  assign tx_data     = r_tx_mem[r_tx_rd];
  assign rx_ready    = (r_rx_cnt != c_CNT_FULL);
  assign tx_overflow = r_tx_overflow;
  assign ram_r_data  = r_rd_data;

  always_comb begin
    w_rd_next = 8'h00;
    if (!ram_rw) begin
      if (!w_io) begin
        w_rd_next = r_ram[ram_addr[RAM_AW-1:0]];
      end else if (w_io_data) begin
        w_rd_next = w_rx_nonempty ? r_rx_mem[r_rx_rd] : 8'h00;
      end else if (w_io_stat) begin
        w_rd_next = {5'b0, r_tx_overflow, w_tx_full, w_rx_nonempty};
      end
    end
  end

  // Storage arrays carry no reset; only their pointers and counts do.
  always_ff @(posedge clock) begin
    if (ram_rw && !w_io) r_ram[ram_addr[RAM_AW-1:0]] <= ram_w_data;
    if (w_tx_push)       r_tx_mem[r_tx_wr] <= ram_w_data;
    if (w_rx_push)       r_rx_mem[r_rx_wr] <= rx_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data     <= 8'h00;
      r_tx_overflow <= 1'b0;
      r_tx_wr       <= '0;
      r_tx_rd       <= '0;
      r_tx_cnt      <= '0;
      r_rx_wr       <= '0;
      r_rx_rd       <= '0;
      r_rx_cnt      <= '0;
    end else begin
      r_rd_data <= w_rd_next;

      if (w_tx_push_req && w_tx_full) begin
        r_tx_overflow <= 1'b1;
      end else if (ram_rw && w_io_stat) begin
        r_tx_overflow <= 1'b0;
      end

      if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - c_CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase

      if (w_rx_push) r_rx_wr <= r_rx_wr + c_PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - c_CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire
